// File: rtl/cuckoo_pkg.sv
// Shared types and hashing helpers for the two-way cuckoo controller and its tag banks.
// Tag 0 marks an empty slot; the left bank folds the low tag slice, the right bank the high slice.
package cuckoo_pkg;

  localparam int TAG_WIDTH   = 12;
  localparam int INDEX_WIDTH = 6;
  localparam int KEY_WIDTH   = TAG_WIDTH + INDEX_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_PROBE  = 3'd2,
    ST_PLACE  = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  typedef enum logic {
    OP_LOOKUP = 1'b0,
    OP_INSERT = 1'b1
  } op_e;

  function automatic logic [TAG_WIDTH-1:0] get_tag(input logic [KEY_WIDTH-1:0] key);
    return key[KEY_WIDTH-1:INDEX_WIDTH];
  endfunction

  function automatic logic [INDEX_WIDTH-1:0] tag_fold(input logic side,
                                                      input logic [TAG_WIDTH-1:0] tag);
    logic [INDEX_WIDTH-1:0] f;
    if (side) begin
      f = tag[TAG_WIDTH-1:TAG_WIDTH-INDEX_WIDTH];
    end else begin
      f = tag[INDEX_WIDTH-1:0];
    end
    return f;
  endfunction

  function automatic logic [INDEX_WIDTH-1:0] get_index(input logic side,
                                                       input logic [KEY_WIDTH-1:0] key);
    return key[INDEX_WIDTH-1:0] ^ tag_fold(side, get_tag(key));
  endfunction

  // Inverse of get_index: recovers the full key of a resident entry from its slot.
  function automatic logic [KEY_WIDTH-1:0] rebuild_key(input logic side,
                                                       input logic [INDEX_WIDTH-1:0] idx,
                                                       input logic [TAG_WIDTH-1:0] tag);
    return {tag, idx ^ tag_fold(side, tag)};
  endfunction

endpackage

// File: rtl/cuckoo_stats.sv
// Saturating 32-bit event counters for cuckoo_ctrl; only instantiated when
// CUCKOO_CTRL_STATS_EN is defined.
module cuckoo_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        ins_inc_i,
  input  logic        fail_inc_i,
  input  logic        kick_inc_i,
  output logic [31:0] stat_ins_o,
  output logic [31:0] stat_fail_o,
  output logic [31:0] stat_kick_o
);

  logic [31:0] ins_q, ins_d;
  logic [31:0] fail_q, fail_d;
  logic [31:0] kick_q, kick_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    logic [31:0] n;
    if (en && (v != 32'hFFFF_FFFF)) begin
      n = v + 32'd1;
    end else begin
      n = v;
    end
    return n;
  endfunction

  always_comb begin
    ins_d  = sat_inc(ins_q, ins_inc_i);
    fail_d = sat_inc(fail_q, fail_inc_i);
    kick_d = sat_inc(kick_q, kick_inc_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ins_q  <= 32'd0;
      fail_q <= 32'd0;
      kick_q <= 32'd0;
    end else begin
      ins_q  <= ins_d;
      fail_q <= fail_d;
      kick_q <= kick_d;
    end
  end

  assign stat_ins_o  = ins_q;
  assign stat_fail_o = fail_q;
  assign stat_kick_o = kick_q;

endmodule

// File: rtl/cuckoo_ctrl.sv
// Insert/lookup sequencer for a two-way cuckoo filter over a left and a right tag bank.
// Statistics counters are built only when CUCKOO_CTRL_STATS_EN is defined.
module cuckoo_ctrl
  import cuckoo_pkg::*;
#(
  parameter int MAX_KICKS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_op_i,
  input  logic [KEY_WIDTH-1:0] req_key_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic                 resp_hit_o,
  output logic                 resp_fail_o,
  output logic                 resp_err_o,
  output logic [KEY_WIDTH-1:0] resp_drop_key_o,
  output logic                 l_read_o,
  output logic                 r_read_o,
  output logic                 l_write_o,
  output logic                 r_write_o,
  output logic [KEY_WIDTH-1:0] l_key_o,
  output logic [KEY_WIDTH-1:0] r_key_o,
  input  logic                 l_hit_i,
  input  logic                 r_hit_i,
  input  logic [TAG_WIDTH-1:0] l_tag_i,
  input  logic [TAG_WIDTH-1:0] r_tag_i,
  output logic [31:0]          stat_ins_o,
  output logic [31:0]          stat_fail_o,
  output logic [31:0]          stat_kick_o
);

  localparam int KW = $clog2(MAX_KICKS + 1);

  state_e               state_q, state_d;
  logic [KEY_WIDTH-1:0] cur_q, cur_d;
  logic                 side_q, side_d;
  logic [KW-1:0]        kicks_q, kicks_d;
  logic                 ready_q, ready_d;
  logic                 rvalid_q, rvalid_d;
  logic                 hit_q, hit_d;
  logic                 fail_q, fail_d;
  logic                 err_q, err_d;
  logic [KEY_WIDTH-1:0] drop_q, drop_d;
  logic                 l_rd_q, l_rd_d, r_rd_q, r_rd_d;
  logic                 l_wr_q, l_wr_d, r_wr_q, r_wr_d;
  logic [KEY_WIDTH-1:0] l_key_q, l_key_d, r_key_q, r_key_d;

  logic [TAG_WIDTH-1:0] old_tag_s;
  logic [KEY_WIDTH-1:0] victim_s;
  logic [KW-1:0]        kicks_inc_s;
  logic                 last_kick_s;
  logic                 probe_side_s;

  assign old_tag_s    = side_q ? r_tag_i : l_tag_i;
  assign victim_s     = rebuild_key(side_q, get_index(side_q, cur_q), old_tag_s);
  assign kicks_inc_s  = kicks_q + KW'(1);
  assign last_kick_s  = (kicks_inc_s == KW'(MAX_KICKS));
  assign probe_side_s = (l_tag_i == {TAG_WIDTH{1'b0}}) ? 1'b0 : (r_tag_i == {TAG_WIDTH{1'b0}});

  // Bank strobes are computed for the state being entered so they are valid as registered outputs.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    side_d   = side_q;
    kicks_d  = kicks_q;
    ready_d  = ready_q;
    rvalid_d = rvalid_q;
    hit_d    = hit_q;
    fail_d   = fail_q;
    err_d    = err_q;
    drop_d   = drop_q;
    l_rd_d   = 1'b0;
    r_rd_d   = 1'b0;
    l_wr_d   = 1'b0;
    r_wr_d   = 1'b0;
    l_key_d  = l_key_q;
    r_key_d  = r_key_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && ready_q) begin
          cur_d   = req_key_i;
          ready_d = 1'b0;
          if (get_tag(req_key_i) == {TAG_WIDTH{1'b0}}) begin
            state_d  = ST_RESP;
            rvalid_d = 1'b1;
            err_d    = 1'b1;
          end else begin
            l_rd_d  = 1'b1;
            r_rd_d  = 1'b1;
            l_key_d = req_key_i;
            r_key_d = req_key_i;
            state_d = (req_op_i == OP_INSERT) ? ST_PROBE : ST_LOOKUP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        state_d  = ST_RESP;
        rvalid_d = 1'b1;
        hit_d    = l_hit_i | r_hit_i;
      end
      ST_PROBE: begin
        if (l_hit_i || r_hit_i) begin
          state_d  = ST_RESP;
          rvalid_d = 1'b1;
          hit_d    = 1'b1;
        end else begin
          state_d = ST_PLACE;
          side_d  = probe_side_s;
          kicks_d = {KW{1'b0}};
          l_rd_d  = ~probe_side_s;
          l_wr_d  = ~probe_side_s;
          r_rd_d  = probe_side_s;
          r_wr_d  = probe_side_s;
          l_key_d = cur_q;
          r_key_d = cur_q;
        end
      end
      ST_PLACE: begin
        if (old_tag_s == {TAG_WIDTH{1'b0}}) begin
          state_d  = ST_RESP;
          rvalid_d = 1'b1;
        end else if (last_kick_s) begin
          state_d  = ST_RESP;
          rvalid_d = 1'b1;
          fail_d   = 1'b1;
          drop_d   = victim_s;
          kicks_d  = kicks_inc_s;
        end else begin
          // The evicted entry moves to the opposite bank on the next cycle.
          cur_d   = victim_s;
          side_d  = ~side_q;
          kicks_d = kicks_inc_s;
          l_rd_d  = side_q;
          l_wr_d  = side_q;
          r_rd_d  = ~side_q;
          r_wr_d  = ~side_q;
          l_key_d = victim_s;
          r_key_d = victim_s;
        end
      end
      ST_RESP: begin
        if (resp_ready_i) begin
          state_d  = ST_IDLE;
          ready_d  = 1'b1;
          rvalid_d = 1'b0;
          hit_d    = 1'b0;
          fail_d   = 1'b0;
          err_d    = 1'b0;
          drop_d   = {KEY_WIDTH{1'b0}};
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        ready_d  = 1'b1;
        rvalid_d = 1'b0;
        hit_d    = 1'b0;
        fail_d   = 1'b0;
        err_d    = 1'b0;
        drop_d   = {KEY_WIDTH{1'b0}};
      end
    endcase
  end

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cur_q    <= {KEY_WIDTH{1'b0}};
      side_q   <= 1'b0;
      kicks_q  <= {KW{1'b0}};
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      hit_q    <= 1'b0;
      fail_q   <= 1'b0;
      err_q    <= 1'b0;
      drop_q   <= {KEY_WIDTH{1'b0}};
      l_rd_q   <= 1'b0;
      r_rd_q   <= 1'b0;
      l_wr_q   <= 1'b0;
      r_wr_q   <= 1'b0;
      l_key_q  <= {KEY_WIDTH{1'b0}};
      r_key_q  <= {KEY_WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      side_q   <= side_d;
      kicks_q  <= kicks_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      hit_q    <= hit_d;
      fail_q   <= fail_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
      l_rd_q   <= l_rd_d;
      r_rd_q   <= r_rd_d;
      l_wr_q   <= l_wr_d;
      r_wr_q   <= r_wr_d;
      l_key_q  <= l_key_d;
      r_key_q  <= r_key_d;
    end
  end

  assign req_ready_o     = ready_q;
  assign resp_valid_o    = rvalid_q;
  assign resp_hit_o      = hit_q;
  assign resp_fail_o     = fail_q;
  assign resp_err_o      = err_q;
  assign resp_drop_key_o = drop_q;
  assign l_read_o        = l_rd_q;
  assign r_read_o        = r_rd_q;
  assign l_write_o       = l_wr_q;
  assign r_write_o       = r_wr_q;
  assign l_key_o         = l_key_q;
  assign r_key_o         = r_key_q;

`ifdef CUCKOO_CTRL_STATS_EN
  logic place_s;
  logic ins_inc_s;
  logic kick_inc_s;
  logic fail_inc_s;

  assign place_s    = (state_q == ST_PLACE);
  assign ins_inc_s  = place_s && (old_tag_s == {TAG_WIDTH{1'b0}});
  assign kick_inc_s = place_s && (old_tag_s != {TAG_WIDTH{1'b0}});
  assign fail_inc_s = kick_inc_s && last_kick_s;

  cuckoo_stats u_stats (
    .clk         (clk),
    .rst         (rst),
    .ins_inc_i   (ins_inc_s),
    .fail_inc_i  (fail_inc_s),
    .kick_inc_i  (kick_inc_s),
    .stat_ins_o  (stat_ins_o),
    .stat_fail_o (stat_fail_o),
    .stat_kick_o (stat_kick_o)
  );
`else
  assign stat_ins_o  = 32'd0;
  assign stat_fail_o = 32'd0;
  assign stat_kick_o = 32'd0;
`endif

endmodule

// File: tb/tb_cuckoo_ctrl.sv
// Directed bench for cuckoo_ctrl (MAX_KICKS=2) with a behavioural pair of tag banks.
module tb_cuckoo_ctrl;
  import cuckoo_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 req_valid_i, req_ready_o, req_op_i;
  logic [KEY_WIDTH-1:0] req_key_i;
  logic                 resp_valid_o, resp_ready_i;
  logic                 resp_hit_o, resp_fail_o, resp_err_o;
  logic [KEY_WIDTH-1:0] resp_drop_key_o;
  logic                 l_read_o, r_read_o, l_write_o, r_write_o;
  logic [KEY_WIDTH-1:0] l_key_o, r_key_o;
  logic                 l_hit_i, r_hit_i;
  logic [TAG_WIDTH-1:0] l_tag_i, r_tag_i;
  logic [31:0]          stat_ins_o, stat_fail_o, stat_kick_o;

  int tests = 0;
  int fails = 0;

`ifdef CUCKOO_CTRL_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  typedef struct {
    int                   lat;
    int                   nrd;
    int                   nwr;
    int                   nrdy;
    logic                 hit;
    logic                 fail;
    logic                 err;
    logic [KEY_WIDTH-1:0] drop;
    logic                 stable;
    logic                 rdy_after;
  } resp_t;

  always #5 clk = ~clk;

  cuckoo_ctrl #(.MAX_KICKS(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i), .req_key_i(req_key_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_hit_o(resp_hit_o), .resp_fail_o(resp_fail_o), .resp_err_o(resp_err_o),
    .resp_drop_key_o(resp_drop_key_o),
    .l_read_o(l_read_o), .r_read_o(r_read_o), .l_write_o(l_write_o), .r_write_o(r_write_o),
    .l_key_o(l_key_o), .r_key_o(r_key_o),
    .l_hit_i(l_hit_i), .r_hit_i(r_hit_i), .l_tag_i(l_tag_i), .r_tag_i(r_tag_i),
    .stat_ins_o(stat_ins_o), .stat_fail_o(stat_fail_o), .stat_kick_o(stat_kick_o)
  );

  // Behavioural banks: combinational read/hit, write on the clock edge, cleared by rst.
  logic [TAG_WIDTH-1:0]   lbank [2**INDEX_WIDTH];
  logic [TAG_WIDTH-1:0]   rbank [2**INDEX_WIDTH];
  logic [INDEX_WIDTH-1:0] l_idx, r_idx;
  logic                   poke_en, poke_side;
  logic [INDEX_WIDTH-1:0] poke_idx;
  logic [TAG_WIDTH-1:0]   poke_tag;

  assign l_idx   = get_index(1'b0, l_key_o);
  assign r_idx   = get_index(1'b1, r_key_o);
  assign l_tag_i = lbank[l_idx];
  assign r_tag_i = rbank[r_idx];
  assign l_hit_i = l_read_o && (lbank[l_idx] == get_tag(l_key_o));
  assign r_hit_i = r_read_o && (rbank[r_idx] == get_tag(r_key_o));

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**INDEX_WIDTH; i++) begin
        lbank[i] <= '0;
        rbank[i] <= '0;
      end
    end else if (poke_en) begin
      if (poke_side) rbank[poke_idx] <= poke_tag;
      else lbank[poke_idx] <= poke_tag;
    end else begin
      if (l_write_o) lbank[l_idx] <= get_tag(l_key_o);
      if (r_write_o) rbank[r_idx] <= get_tag(r_key_o);
    end
  end

  task automatic poke(input logic side, input logic [INDEX_WIDTH-1:0] idx, input logic [TAG_WIDTH-1:0] tag);
    poke_en = 1'b1; poke_side = side; poke_idx = idx; poke_tag = tag;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Issues one request from a negedge and completes the response handshake.
  // lat = number of the edge (after acceptance edge N) at which resp_valid_o is first seen.
  task automatic run_req(input logic op, input logic [KEY_WIDTH-1:0] key, output resp_t r);
    r.lat = 1; r.nrd = 0; r.nwr = 0; r.nrdy = 0;
    req_valid_i = 1'b1; req_op_i = op; req_key_i = key;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    @(negedge clk);
    while (resp_valid_o !== 1'b1 && r.lat < 40) begin
      if (l_read_o || r_read_o) r.nrd++;
      if (l_write_o || r_write_o) r.nwr++;
      if (req_ready_o) r.nrdy++;
      @(negedge clk);
      r.lat++;
    end
    r.hit = resp_hit_o; r.fail = resp_fail_o; r.err = resp_err_o; r.drop = resp_drop_key_o;
    @(negedge clk);
    r.stable = (resp_valid_o === 1'b1) && (resp_hit_o === r.hit) && (resp_fail_o === r.fail) &&
               (resp_err_o === r.err) && (resp_drop_key_o === r.drop) && (req_ready_o === 1'b0) &&
               ({l_read_o, r_read_o, l_write_o, r_write_o} === 4'b0000);
    resp_ready_i = 1'b1;
    @(negedge clk);
    resp_ready_i = 1'b0;
    r.rdy_after = (req_ready_o === 1'b1) && (resp_valid_o === 1'b0);
  endtask

  task automatic test_reset();
    tests++; if (req_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", req_ready_o); end
    tests++; if (resp_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", resp_valid_o); end
    tests++; if ({resp_hit_o, resp_fail_o, resp_err_o, resp_drop_key_o} !== '0) begin fails++; $display("FAIL reset_resp got %b%b%b %h want all 0", resp_hit_o, resp_fail_o, resp_err_o, resp_drop_key_o); end
    tests++; if ({l_read_o, r_read_o, l_write_o, r_write_o} !== 4'b0000) begin fails++; $display("FAIL reset_en got %b want 0000", {l_read_o, r_read_o, l_write_o, r_write_o}); end
    tests++; if ({stat_ins_o, stat_fail_o, stat_kick_o} !== 96'd0) begin fails++; $display("FAIL reset_stats got %0d %0d %0d want 0 0 0", stat_ins_o, stat_fail_o, stat_kick_o); end
  endtask

  task automatic test_lookup_miss();
    resp_t r;
    run_req(1'b0, 18'h00041, r);
    tests++; if (r.lat !== 2) begin fails++; $display("FAIL miss_lat got %0d want 2", r.lat); end
    tests++; if (r.hit !== 1'b0 || r.err !== 1'b0) begin fails++; $display("FAIL miss_hit got hit=%b err=%b want 0 0", r.hit, r.err); end
    tests++; if (r.nwr !== 0 || r.nrd !== 1) begin fails++; $display("FAIL miss_access got rd=%0d wr=%0d want 1 0", r.nrd, r.nwr); end
    tests++; if (r.nrdy !== 0) begin fails++; $display("FAIL miss_busy_ready got %0d want 0", r.nrdy); end
    tests++; if (!r.stable || !r.rdy_after) begin fails++; $display("FAIL miss_handshake got stable=%b rdy=%b want 1 1", r.stable, r.rdy_after); end
  endtask

  task automatic test_insert();
    resp_t r;
    run_req(1'b1, 18'h00041, r);
    tests++; if (r.lat !== 3) begin fails++; $display("FAIL ins_lat got %0d want 3", r.lat); end
    tests++; if ({r.hit, r.fail, r.err} !== 3'b000) begin fails++; $display("FAIL ins_resp got %b%b%b want 000", r.hit, r.fail, r.err); end
    tests++; if (r.nwr !== 1) begin fails++; $display("FAIL ins_writes got %0d want 1", r.nwr); end
    tests++; if (lbank[0] !== 12'h001 || rbank[1] !== 12'h000) begin fails++; $display("FAIL ins_slot got l0=%h r1=%h want 001 000", lbank[0], rbank[1]); end
    tests++; if (stat_ins_o !== (STATS_ON ? 32'd1 : 32'd0)) begin fails++; $display("FAIL ins_stat got %0d want %0d", stat_ins_o, STATS_ON ? 1 : 0); end
    run_req(1'b0, 18'h00041, r);
    tests++; if (r.lat !== 2 || r.hit !== 1'b1) begin fails++; $display("FAIL ins_lookup got lat=%0d hit=%b want 2 1", r.lat, r.hit); end
  endtask

  task automatic test_dup_insert();
    resp_t r;
    run_req(1'b1, 18'h00041, r);
    tests++; if (r.lat !== 2 || r.hit !== 1'b1) begin fails++; $display("FAIL dup_resp got lat=%0d hit=%b want 2 1", r.lat, r.hit); end
    tests++; if (r.nwr !== 0) begin fails++; $display("FAIL dup_writes got %0d want 0", r.nwr); end
    tests++; if (stat_ins_o !== (STATS_ON ? 32'd1 : 32'd0)) begin fails++; $display("FAIL dup_stat got %0d want %0d", stat_ins_o, STATS_ON ? 1 : 0); end
  endtask

  task automatic test_zero_tag();
    resp_t r;
    run_req(1'b1, 18'h0003F, r);
    tests++; if (r.lat !== 1 || r.err !== 1'b1) begin fails++; $display("FAIL zt_ins got lat=%0d err=%b want 1 1", r.lat, r.err); end
    tests++; if (r.nrd !== 0 || r.hit !== 1'b0) begin fails++; $display("FAIL zt_noread got rd=%0d hit=%b want 0 0", r.nrd, r.hit); end
    tests++; if (!r.stable || !r.rdy_after) begin fails++; $display("FAIL zt_handshake got stable=%b rdy=%b want 1 1", r.stable, r.rdy_after); end
    run_req(1'b0, 18'h0003F, r);
    tests++; if (r.lat !== 1 || r.err !== 1'b1) begin fails++; $display("FAIL zt_lookup got lat=%0d err=%b want 1 1", r.lat, r.err); end
  endtask

  // Key 0x00090 finds both slots taken; the left resident moves to a free right slot.
  task automatic test_kick_ok();
    resp_t r;
    poke(1'b0, 6'h12, 12'h045);
    poke(1'b1, 6'h10, 12'h200);
    run_req(1'b1, 18'h00090, r);
    tests++; if (r.lat !== 4 || r.nwr !== 2) begin fails++; $display("FAIL kok_timing got lat=%0d wr=%0d want 4 2", r.lat, r.nwr); end
    tests++; if ({r.hit, r.fail, r.err} !== 3'b000 || r.drop !== 18'h0) begin fails++; $display("FAIL kok_resp got %b%b%b drop=%h want 000 0", r.hit, r.fail, r.err, r.drop); end
    tests++; if (lbank[6'h12] !== 12'h002 || rbank[6'h16] !== 12'h045) begin fails++; $display("FAIL kok_banks got l12=%h r16=%h want 002 045", lbank[6'h12], rbank[6'h16]); end
    tests++; if (stat_ins_o !== (STATS_ON ? 32'd2 : 32'd0) || stat_kick_o !== (STATS_ON ? 32'd1 : 32'd0)) begin fails++; $display("FAIL kok_stats got ins=%0d kick=%0d", stat_ins_o, stat_kick_o); end
  endtask

  // Key 0x01040 evicts 0x02001 to right slot 3, which evicts 0x03000 at the kick limit.
  task automatic test_kick_fail();
    resp_t r;
    poke(1'b0, 6'h01, 12'h080);
    poke(1'b1, 6'h01, 12'h100);
    poke(1'b1, 6'h03, 12'h0C0);
    run_req(1'b1, 18'h01040, r);
    tests++; if (r.lat !== 4 || r.nwr !== 2) begin fails++; $display("FAIL kf_timing got lat=%0d wr=%0d want 4 2", r.lat, r.nwr); end
    tests++; if (r.fail !== 1'b1 || r.hit !== 1'b0 || r.err !== 1'b0) begin fails++; $display("FAIL kf_resp got fail=%b hit=%b err=%b want 1 0 0", r.fail, r.hit, r.err); end
    tests++; if (r.drop !== 18'h03000) begin fails++; $display("FAIL kf_drop got %h want 03000", r.drop); end
    tests++; if (!r.stable || !r.rdy_after) begin fails++; $display("FAIL kf_handshake got stable=%b rdy=%b want 1 1", r.stable, r.rdy_after); end
    tests++; if (lbank[1] !== 12'h041 || rbank[3] !== 12'h080) begin fails++; $display("FAIL kf_banks got l1=%h r3=%h want 041 080", lbank[1], rbank[3]); end
    tests++; if (stat_fail_o !== (STATS_ON ? 32'd1 : 32'd0) || stat_kick_o !== (STATS_ON ? 32'd3 : 32'd0) || stat_ins_o !== (STATS_ON ? 32'd2 : 32'd0)) begin fails++; $display("FAIL kf_stats got ins=%0d fail=%0d kick=%0d", stat_ins_o, stat_fail_o, stat_kick_o); end
    run_req(1'b0, 18'h01040, r);
    tests++; if (r.hit !== 1'b1) begin fails++; $display("FAIL kf_key_hit got %b want 1", r.hit); end
    run_req(1'b0, 18'h03000, r);
    tests++; if (r.hit !== 1'b0) begin fails++; $display("FAIL kf_drop_miss got %b want 0", r.hit); end
  endtask

  task automatic test_reset_mid();
    resp_t r;
    req_valid_i = 1'b1; req_op_i = 1'b1; req_key_i = 18'h00500;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++; if (l_write_o !== 1'b1) begin fails++; $display("FAIL rm_place got l_write=%b want 1", l_write_o); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin fails++; $display("FAIL rm_state got ready=%b valid=%b want 1 0", req_ready_o, resp_valid_o); end
    tests++; if ({l_read_o, r_read_o, l_write_o, r_write_o} !== 4'b0000) begin fails++; $display("FAIL rm_en got %b want 0000", {l_read_o, r_read_o, l_write_o, r_write_o}); end
    run_req(1'b0, 18'h00500, r);
    tests++; if (r.lat !== 2 || r.hit !== 1'b0) begin fails++; $display("FAIL rm_lookup got lat=%0d hit=%b want 2 0", r.lat, r.hit); end
    run_req(1'b0, 18'h00041, r);
    tests++; if (r.hit !== 1'b0) begin fails++; $display("FAIL rm_cleared got %b want 0", r.hit); end
    tests++; if ({stat_ins_o, stat_fail_o, stat_kick_o} !== 96'd0) begin fails++; $display("FAIL rm_stats got %0d %0d %0d want 0 0 0", stat_ins_o, stat_fail_o, stat_kick_o); end
  endtask

  task automatic test_back_to_back();
    resp_t r;
    run_req(1'b1, 18'h00041, r);
    tests++; if (r.lat !== 3 || !r.rdy_after) begin fails++; $display("FAIL b2b_ins got lat=%0d rdy=%b want 3 1", r.lat, r.rdy_after); end
    run_req(1'b0, 18'h00041, r);
    tests++; if (r.lat !== 2 || r.hit !== 1'b1) begin fails++; $display("FAIL b2b_lookup got lat=%0d hit=%b want 2 1", r.lat, r.hit); end
    tests++; if (stat_ins_o !== (STATS_ON ? 32'd1 : 32'd0)) begin fails++; $display("FAIL b2b_stat got %0d want %0d", stat_ins_o, STATS_ON ? 1 : 0); end
  endtask

  initial begin
    rst = 1'b1; req_valid_i = 1'b0; req_op_i = 1'b0; req_key_i = '0; resp_ready_i = 1'b0;
    poke_en = 1'b0; poke_side = 1'b0; poke_idx = '0; poke_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_lookup_miss();
    test_insert();
    test_dup_insert();
    test_zero_tag();
    test_kick_ok();
    test_kick_fail();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cuckoo_ctrl.md
# cuckoo_ctrl

Insert/lookup sequencer for a pair of skewed tag banks, a left bank (hash side 0) and a right bank (hash side 1), organised as a two-way cuckoo filter. It accepts one request at a time from a valid/ready requester port. Lookups probe both banks in parallel. Inserts place the key in a free slot or relocate resident entries across sides, bounded by a kick limit. It sits between the request source and the two bank instances and is the only driver of their read/write ports.

## Interface
- TAG_WIDTH, 12: stored tag bits.
- INDEX_WIDTH, 6: bank index bits; KEY_WIDTH = TAG_WIDTH + INDEX_WIDTH.
- MAX_KICKS, 16: maximum relocations per insert (≥1).
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- req_valid_i / req_ready_o  in/out  1  request handshake.
- req_op_i  in  1  0 = lookup, 1 = insert.
- req_key_i  in  KEY_WIDTH  key.
- resp_valid_o / resp_ready_i  out/in  1  response handshake.
- resp_hit_o  out  1  key already present.
- resp_fail_o  out  1  insert aborted at kick limit.
- resp_err_o  out  1  key rejected (zero tag).
- resp_drop_key_o  out  KEY_WIDTH  key lost on fail; otherwise 0.
- l_read_o, r_read_o  out  1  bank read enables.
- l_write_o, r_write_o  out  1  bank write enables.
- l_key_o, r_key_o  out  KEY_WIDTH  key driven to both the bank read address and the bank write data.
- l_hit_i, r_hit_i  in  1  combinational bank hit.
- l_tag_i, r_tag_i  in  TAG_WIDTH  combinational tag stored at the addressed slot.
- stat_ins_o, stat_fail_o, stat_kick_o  out  32  statistics counters.

## Operation
- Hashing: tag = key[KEY_WIDTH-1:INDEX_WIDTH]; left idx = key[5:0]^key[11:6]; right idx = key[5:0]^key[17:12] (generalised by INDEX_WIDTH).
- Tag 0 marks an empty slot. A key whose tag is 0 returns resp_err_o=1 for both ops. No bank access is made for it.
- Victim rebuild from (side, slot idx, tag):
  - left: low = idx ^ tag[INDEX_WIDTH-1:0].
  - right: low = idx ^ tag[TAG_WIDTH-1:TAG_WIDTH-INDEX_WIDTH].
- FSM states: IDLE, LOOKUP, PROBE, PLACE, RESP.
- IDLE: req_ready_o=1. On accept, register the op and key.
  - Zero-tag key → RESP with err.
  - lookup → LOOKUP; insert → PROBE.
- LOOKUP: assert both reads. resp_hit_o = l_hit_i | r_hit_i. Go to RESP.
- PROBE: assert both reads.
  - Either bank hits → RESP, hit=1, no write.
  - Otherwise, choose the start side: left if l_tag_i==0, else right if r_tag_i==0, else left. cur = key, kicks = 0. Go to PLACE.
- PLACE(side): assert read and write on that side with cur.
  - Old tag == 0 → RESP, ok.
  - Otherwise cur = rebuilt victim, side flips, kicks++.
  - kicks reaching MAX_KICKS → RESP with fail=1 and resp_drop_key_o = victim.
- RESP: resp_valid_o=1 and all response fields held stable until resp_ready_i. Then go to IDLE.
- Bank enables are 0 in IDLE and RESP.
- Reset values:
  - state IDLE.
  - req_ready_o=1.
  - resp_valid_o and all resp_* outputs 0.
  - All bank enables 0.
  - Counters 0.
- Reset mid-operation: FSM returns to IDLE on the next edge and any partial relocation is abandoned. The banks clear on the same rst.

## Timing
- Accept at edge N (req_valid_i & req_ready_o).
- Lookup: LOOKUP in cycle N+1; resp_valid_o rises at edge N+2.
- Insert, found or free slot: PROBE in N+1, PLACE in N+2; resp_valid_o at N+3 (N+2 if found).
- Each relocation adds 1 cycle. A failed insert takes MAX_KICKS PLACE cycles.
- Error response: resp_valid_o at N+1.
- Only one request is outstanding; req_ready_o=0 from N+1 until the response handshake completes.
- A new request may be accepted on the cycle after the response handshake.

## Configuration
- CUCKOO_CTRL_STATS_EN defined: saturating 32-bit counters.
  - stat_ins_o: successful inserts.
  - stat_fail_o: failed inserts.
  - stat_kick_o: total relocations.
- Undefined: counters are not built and the stat outputs are tied 0.

## Structure
- cuckoo_pkg holds:
  - state enum and op encoding.
  - KEY_WIDTH.
  - get_tag, get_index(side) and rebuild_key(side, idx, tag) functions, shared with the bank instances.
- One sub-module, cuckoo_stats (the three counters), instantiated only under the macro.

## Test plan
- After reset, lookup 0x00041 → resp_hit_o=0 at N+2; bank writes stay 0 throughout.
- Insert 0x00041 → PLACE on left slot 0x00, resp ok at N+3; then lookup 0x00041 → hit=1.
- Insert 0x00041 again → hit=1 at N+2, no write strobe; stat_ins_o unchanged (stats build).
- Insert 0x0003F (tag 0) → resp_err_o=1 at N+1, no bank reads.
- MAX_KICKS=2, with both candidate slots of a key and of its victims occupied → exactly 2 PLACE cycles, resp_fail_o=1, resp_drop_key_o equals the second victim, stat_fail_o=1.
- rst asserted during PLACE → req_ready_o=1 and resp_valid_o=0 next cycle; a subsequent lookup of the in-flight key misses.
